mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) requester and its load/store (MEM) requester.
- Sequences each access through a 3-state FSM. It holds the losing requester until its own access completes, so the pipeline's IF/MEM stall logic uses this block's stall outputs.
- Supports IF cancellation on branch/jump redirect, a fairness limit against IF starvation, and a bus watchdog.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_watchdog.sv | 31 +++
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, access owner and
// the byte-strobe width rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    localparam int BYTE_BITS      = 8;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int STRB_WIDTH_DEF = DATA_WIDTH_DEF / BYTE_BITS;

    function automatic int strb_width(input int data_width);
        return data_width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Bus watchdog: saturating cycle counter, cleared outside the bus phase,
// flagging expiry once it has counted LIMIT-1 cycles.
module mem_arb_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// one access at a time through IDLE -> BUS -> RESP.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int  MAX_MEM_STREAK = 4,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int BE_WIDTH       = strb_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_done,
    output logic                  if_stall,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [BE_WIDTH-1:0]   mem_be,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_done,
    output logic                  mem_stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [BE_WIDTH-1:0]   bus_be,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  timeout_err
);

    localparam int SW = $clog2(MAX_MEM_STREAK + 1);

    state_t                r_state;
    owner_t                r_owner;
    logic [SW-1:0]         r_streak;
    logic                  r_discard;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [BE_WIDTH-1:0]   r_bus_be;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_mem_rdata;
    logic                  r_if_done;
    logic                  r_mem_done;
    logic                  r_timeout;

    logic w_streak_full;
    logic w_grant_if;
    logic w_grant_mem;
    logic w_wd_expired;
    logic w_if_drop;

    // MEM normally wins; a saturated streak hands the slot to a waiting IF.
    assign w_streak_full = (r_streak == SW'(MAX_MEM_STREAK));
    assign w_grant_if    = (r_state == IDLE) && if_req && !if_flush && (!mem_req || w_streak_full);
    assign w_grant_mem   = (r_state == IDLE) && mem_req && !w_grant_if;
    assign w_if_drop     = r_discard || if_flush;

    mem_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != BUS),
        .i_en      ((r_state == BUS) && !bus_ack),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_streak    <= '0;
            r_discard   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_timeout  <= 1'b0;

            if (!if_req || w_grant_if) begin
                r_streak <= '0;
            end else if (w_grant_mem && !w_streak_full) begin
                r_streak <= r_streak + SW'(1);
            end

            case (r_state)
                IDLE: begin
                    r_discard <= 1'b0;
                    if (w_grant_if) begin
                        r_owner     <= OWN_IF;
                        r_bus_we    <= 1'b0;
                        r_bus_be    <= '1;
                        r_bus_addr  <= if_addr;
                        r_bus_wdata <= '0;
                        r_bus_req   <= 1'b1;
                        r_state     <= BUS;
                    end else if (w_grant_mem) begin
                        r_owner     <= OWN_MEM;
                        r_bus_we    <= mem_we;
                        r_bus_be    <= mem_be;
                        r_bus_addr  <= mem_addr;
                        r_bus_wdata <= mem_wdata;
                        r_bus_req   <= 1'b1;
                        r_state     <= BUS;
                    end
                end
                BUS: begin
                    if ((r_owner == OWN_IF) && if_flush) begin
                        r_discard <= 1'b1;
                    end
                    // An ack in the expiry cycle still wins over the watchdog.
                    if (bus_ack || w_wd_expired) begin
                        r_bus_req <= 1'b0;
                        r_timeout <= !bus_ack;
                        r_state   <= RESP;
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= bus_ack ? bus_rdata : '0;
                            r_if_done  <= !w_if_drop;
                        end else begin
                            r_mem_rdata <= bus_ack ? bus_rdata : '0;
                            r_mem_done  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_discard <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_be      = r_bus_be;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign if_rdata    = r_if_rdata;
    assign mem_rdata   = r_mem_rdata;
    assign if_done     = r_if_done;
    assign mem_done    = r_mem_done;
    assign timeout_err = r_timeout;
    assign if_stall    = if_req & ~r_if_done;
    assign mem_stall   = mem_req & ~r_mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester/memory agents, a transaction-rule
// model compared every cycle, and literal checks for each scenario.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;
    localparam int TO   = 8;

    typedef struct {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mreq_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, mem_req, mem_we, bus_ack;
    logic [AW-1:0] if_addr, mem_addr;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata, bus_rdata;
    logic [DW-1:0] if_rdata, mem_rdata, bus_wdata;
    logic          if_done, if_stall, mem_done, mem_stall, bus_req, bus_we, timeout_err;
    logic [BW-1:0] bus_be;
    logic [AW-1:0] bus_addr;

    mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_MEM_STREAK (MAXS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_flush    (if_flush),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .if_stall    (if_stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .mem_stall   (mem_stall),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_be      (bus_be),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    logic [AW-1:0] if_q[$];
    mreq_t         mem_q[$];
    int            ack_at    = 1;
    int            ack_age   = 0;
    logic          stale_ack = 1'b0;
    logic [DW-1:0] rd_val    = '0;
    logic [AW-1:0] grant_log[$];
    int            n_to      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: what the outputs must be, from the arbitration rules.
    bit            m_busy, m_resp, m_who_mem, m_drop;
    int            m_age, m_streak;
    logic          e_bus_req, e_we, e_if_done, e_mem_done, e_timeout;
    logic [BW-1:0] e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_if_rdata, e_mem_rdata;

    task automatic model_step();
        bit if_turn, mem_turn;
        if_turn  = 1'b0;
        mem_turn = 1'b0;
        if (!rst) begin
            m_busy = 0; m_resp = 0; m_drop = 0; m_streak = 0; m_age = 0; m_who_mem = 0;
            e_bus_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
            e_if_rdata = '0; e_mem_rdata = '0; e_if_done = 0; e_mem_done = 0; e_timeout = 0;
        end else begin
            e_if_done = 0; e_mem_done = 0; e_timeout = 0;
            if (m_resp) begin
                m_resp = 0;
                m_drop = 0;
            end else if (m_busy) begin
                m_age++;
                if (!m_who_mem && if_flush) m_drop = 1;
                if (bus_ack || m_age == TO) begin
                    m_busy = 0; m_resp = 1; e_bus_req = 0;
                    e_timeout = !bus_ack;
                    if (m_who_mem) begin
                        e_mem_rdata = bus_ack ? bus_rdata : '0;
                        e_mem_done  = 1;
                    end else begin
                        e_if_rdata = bus_ack ? bus_rdata : '0;
                        e_if_done  = !m_drop;
                    end
                end
            end else begin
                if_turn  = if_req && !if_flush && (!mem_req || m_streak >= MAXS);
                mem_turn = mem_req && !if_turn;
                if (if_turn || mem_turn) begin
                    m_busy = 1; m_age = 0; e_bus_req = 1; m_who_mem = mem_turn;
                    e_addr  = mem_turn ? mem_addr : if_addr;
                    e_we    = mem_turn ? mem_we : 1'b0;
                    e_be    = mem_turn ? mem_be : '1;
                    e_wdata = mem_wdata;
                end
            end
            if (!if_req || if_turn) m_streak = 0;
            else if (mem_turn) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("bus_req", 64'(bus_req), 64'(e_bus_req));
            if (e_bus_req) begin
                check("bus_addr", 64'(bus_addr), 64'(e_addr));
                check("bus_we", 64'(bus_we), 64'(e_we));
                check("bus_be", 64'(bus_be), 64'(e_be));
                if (m_who_mem) check("bus_wdata", 64'(bus_wdata), 64'(e_wdata));
            end
            check("if_done", 64'(if_done), 64'(e_if_done));
            check("mem_done", 64'(mem_done), 64'(e_mem_done));
            check("timeout_err", 64'(timeout_err), 64'(e_timeout));
            check("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
            check("mem_rdata", 64'(mem_rdata), 64'(e_mem_rdata));
            check("if_stall", 64'(if_stall), 64'(if_req & ~e_if_done));
            check("mem_stall", 64'(mem_stall), 64'(mem_req & ~e_mem_done));
        end
    end

    // Memory responder and requester agents, all driven just after the edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (bus_req) begin
            ack_age++;
            bus_ack = (ack_age == ack_at);
        end else begin
            ack_age = 0;
            bus_ack = stale_ack;
        end
        bus_rdata = rd_val;
        if (if_req && if_done) begin
            if_req = 1'b0;
            void'(if_q.pop_front());
        end
        if (!if_req && rst && if_q.size() > 0) begin
            if_req  = 1'b1;
            if_addr = if_q[0];
        end
        if (mem_req && mem_done) begin
            mem_req = 1'b0;
            void'(mem_q.pop_front());
        end
        if (!mem_req && rst && mem_q.size() > 0) begin
            mem_req   = 1'b1;
            mem_we    = mem_q[0].we;
            mem_be    = mem_q[0].be;
            mem_addr  = mem_q[0].addr;
            mem_wdata = mem_q[0].wdata;
        end
    end

    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (bus_req && !prev_req) grant_log.push_back(bus_addr);
            prev_req = bus_req;
            if (timeout_err) n_to++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_sig(input int sel, input int limit, input string name, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = bus_req;
                1:       hit = if_done;
                2:       hit = mem_done;
                default: hit = timeout_err;
            endcase
            if (hit) at = cyc;
        end
        check({name, "_seen"}, 64'(at >= 0), 64'd1);
    endtask

    task automatic wait_quiet(input int limit, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = (if_q.size() == 0) && (mem_q.size() == 0) && !bus_req && !if_req && !mem_req;
        end
        check({name, "_quiet"}, 64'(ok), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g, d, md, id, t, n, to0;
        mreq_t r;
        rst = 1'b0; if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0; bus_ack = 0;
        if_addr = '0; mem_addr = '0; mem_be = '0; mem_wdata = '0; bus_rdata = '0;
        step();
        chk_on = 1'b1;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        check("rst_if_done", 64'(if_done), 64'd0);

        // 1: IF-only fetch, ack in first BUS cycle
        step();
        ack_at = 1; rd_val = 32'h0050_0113;
        if_q.push_back(32'h0000_0010);
        wait_sig(0, 10, "t1_grant", g);
        check("t1_bus_be", 64'(bus_be), 64'hF);
        check("t1_bus_we", 64'(bus_we), 64'd0);
        check("t1_bus_addr", 64'(bus_addr), 64'h10);
        wait_sig(1, 10, "t1_done", d);
        check("t1_latency", 64'(d - g + 1), 64'd2);
        check("t1_if_rdata", 64'(if_rdata), 64'h0050_0113);
        wait_quiet(10, "t1");

        // 2: simultaneous IF and MEM store -> MEM first
        step();
        rd_val = 32'h1111_2222;
        r.we = 1'b1; r.be = 4'h3; r.addr = 32'h100; r.wdata = 32'hDEAD_BEEF;
        mem_q.push_back(r);
        if_q.push_back(32'h0000_0020);
        wait_sig(0, 10, "t2_grant", g);
        check("t2_bus_be", 64'(bus_be), 64'h3);
        check("t2_bus_we", 64'(bus_we), 64'd1);
        check("t2_bus_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
        wait_sig(2, 10, "t2_mem_done", md);
        wait_sig(1, 10, "t2_if_done", id);
        check("t2_if_after_mem", 64'(id - md), 64'd3);
        wait_quiet(10, "t2");

        // 3: continuous MEM stream with IF pending -> fairness after 4 grants
        step();
        grant_log.delete();
        for (int i = 0; i < 5; i++) begin
            r.we = 1'b1; r.be = 4'hF; r.addr = 32'h200 + 32'(4 * i); r.wdata = 32'(i);
            mem_q.push_back(r);
        end
        if_q.push_back(32'h0000_0040);
        wait_quiet(60, "t3");
        check("t3_grants", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            logic [AW-1:0] exp_a;
            exp_a = (i < 4) ? 32'h200 + 32'(4 * i) : (i == 4) ? 32'h40 : 32'h210;
            check("t3_order", 64'(grant_log[i]), 64'(exp_a));
        end

        // 4: flush in second BUS cycle of an IF access, ack 3 cycles later
        step();
        ack_at = 5; rd_val = 32'h0000_0AAA;
        if_q.push_back(32'h0000_0080);
        wait_sig(0, 10, "t4_grant", g);
        step();
        if_flush = 1'b1; if_req = 1'b0;
        void'(if_q.pop_front());
        step();
        if_flush = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_done) n++;
        end
        check("t4_no_done", 64'(n), 64'd0);
        check("t4_idle", 64'(bus_req), 64'd0);
        step();
        ack_at = 1; rd_val = 32'h0000_0513;
        if_q.push_back(32'h0000_0084);
        wait_sig(1, 10, "t4_refetch", d);
        check("t4_if_rdata", 64'(if_rdata), 64'h0000_0513);
        wait_quiet(10, "t4");

        // 4b: if_flush with if_req rising in IDLE -> no grant that cycle
        step();
        rd_val = 32'h0000_0777;
        if_q.push_back(32'h0000_00A0);
        if_req = 1'b1; if_addr = 32'h0000_00A0; if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        @(negedge clk);
        check("t4b_no_grant", 64'(bus_req), 64'd0);
        wait_sig(1, 10, "t4b_done", d);
        check("t4b_if_rdata", 64'(if_rdata), 64'h0000_0777);
        wait_quiet(10, "t4b");

        // 5: no ack -> timeout after 8 BUS cycles, MEM done with rdata 0
        step();
        ack_at = 0; rd_val = 32'h5555_5555;
        r.we = 1'b0; r.be = 4'hF; r.addr = 32'h300; r.wdata = '0;
        mem_q.push_back(r);
        wait_sig(0, 10, "t5_grant", g);
        wait_sig(3, 20, "t5_timeout", t);
        check("t5_bus_cycles", 64'(t - g), 64'd8);
        check("t5_mem_done", 64'(mem_done), 64'd1);
        check("t5_mem_rdata", 64'(mem_rdata), 64'd0);
        wait_quiet(10, "t5");

        // 5b: ack in the expiry cycle -> ack wins, no error
        step();
        to0 = n_to;
        ack_at = 8; rd_val = 32'hCAFE_0001;
        if_q.push_back(32'h0000_0050);
        wait_sig(0, 10, "t5b_grant", g);
        wait_sig(1, 20, "t5b_done", d);
        check("t5b_latency", 64'(d - g), 64'd8);
        check("t5b_if_rdata", 64'(if_rdata), 64'hCAFE_0001);
        check("t5b_no_timeout", 64'(n_to - to0), 64'd0);
        wait_quiet(10, "t5b");

        // 6: reset during BUS, then a stale ack
        step();
        ack_at = 0; rd_val = 32'h9999_0000;
        if_q.push_back(32'h0000_0090);
        wait_sig(0, 10, "t6_grant", g);
        step();
        step();
        rst = 1'b0; if_req = 1'b0; if_q.delete();
        step();
        rst = 1'b1; stale_ack = 1'b1;
        @(negedge clk);
        check("t6_bus_req", 64'(bus_req), 64'd0);
        check("t6_bus_addr", 64'(bus_addr), 64'd0);
        check("t6_bus_be", 64'(bus_be), 64'd0);
        check("t6_if_rdata", 64'(if_rdata), 64'd0);
        check("t6_mem_rdata", 64'(mem_rdata), 64'd0);
        step();
        stale_ack = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_done || mem_done || bus_req || timeout_err) n++;
        end
        check("t6_stale_ignored", 64'(n), 64'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
